// File: rtl/mux4to1.sv
// N-bit 4-to-1 multiplexer with a zero-latency combinational output and an
// enable-gated registered copy of the result and its select.
module mux4to1 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic [1:0]   S,
  input  logic         EN,
  output logic [N-1:0] Y,
  output logic [N-1:0] Y_Q,
  output logic [1:0]   S_Q
);

  // An unknown select falls through to A so no case can leave Y unassigned.
  function automatic logic [N-1:0] mux_sel(
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic [N-1:0] c,
    input logic [N-1:0] d,
    input logic [1:0]   sel
  );
    logic [N-1:0] res;
    case (sel)
      2'b00:   res = a;
      2'b01:   res = b;
      2'b10:   res = c;
      2'b11:   res = d;
      default: res = a;
    endcase
    return res;
  endfunction

  // Stage p0: combinational select, independent of clock, reset and enable.
  always_comb begin
    Y = mux_sel(A, B, C, D, S);
  end

  // Stage p1: capture the same value Y shows at the edge, with its select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_Q <= '0;
      S_Q <= 2'b00;
    end else if (EN) begin
      Y_Q <= Y;
      S_Q <= S;
    end
  end

endmodule

// File: tb/tb_mux4to1.sv
// Randomised and directed bench for mux4to1 at N=32, N=1 and N=64 against a
// table-lookup reference model with an edge-driven capture model.
module tb_mux4to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  s;

  logic [31:0] a, b, c, d, y, yq;
  logic [1:0]  sq;
  logic        a1, b1, c1, d1, y1, yq1;
  logic [1:0]  sq1;
  logic [63:0] a64, b64, c64, d64, y64, yq64;
  logic [1:0]  sq64;

  logic [31:0] exp_yq;
  logic [1:0]  exp_sq;
  logic        exp_yq1;
  logic [63:0] exp_yq64;

  int n_checks = 0;
  int n_fail   = 0;

  mux4to1 #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .S(s), .EN(en),
    .Y(y), .Y_Q(yq), .S_Q(sq)
  );

  mux4to1 #(.N(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .C(c1), .D(d1), .S(s), .EN(en),
    .Y(y1), .Y_Q(yq1), .S_Q(sq1)
  );

  mux4to1 #(.N(64)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .A(a64), .B(b64), .C(c64), .D(d64), .S(s), .EN(en),
    .Y(y64), .Y_Q(yq64), .S_Q(sq64)
  );

  always #5 clk = ~clk;

  // Reference selection: the four inputs form a table indexed by the select.
  function automatic logic [63:0] pick(input logic [63:0] p0, input logic [63:0] p1,
                                       input logic [63:0] p2, input logic [63:0] p3,
                                       input logic [1:0] sel);
    logic [63:0] tbl [4];
    tbl = '{p0, p1, p2, p3};
    return tbl[sel];
  endfunction

  // Capture model: at each rising edge out of reset with enable high, store
  // what the table lookup gives for the inputs present at that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && en === 1'b1) begin
        exp_yq   = 32'(pick(a, b, c, d, s));
        exp_yq1  = 1'(pick(a1, b1, c1, d1, s));
        exp_yq64 = pick(a64, b64, c64, d64, s);
        exp_sq   = s;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, "_y"},   y,   pick(a, b, c, d, s));
    check({tag, "_y1"},  y1,  pick(a1, b1, c1, d1, s));
    check({tag, "_y64"}, y64, pick(a64, b64, c64, d64, s));
  endtask

  task automatic check_reg(input string tag);
    check({tag, "_yq"},   yq,   exp_yq);
    check({tag, "_sq"},   sq,   exp_sq);
    check({tag, "_yq1"},  yq1,  exp_yq1);
    check({tag, "_sq1"},  sq1,  exp_sq);
    check({tag, "_yq64"}, yq64, exp_yq64);
    check({tag, "_sq64"}, sq64, exp_sq);
  endtask

  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    exp_yq   = '0;
    exp_yq1  = 1'b0;
    exp_yq64 = '0;
    exp_sq   = 2'b00;
    #1;
    check_reg(tag);
    check_comb({tag, "_live"});
  endtask

  task automatic set_std_data();
    a = 32'hAAAA_AAAA; b = 32'hBBBB_BBBB; c = 32'hCCCC_CCCC; d = 32'hDDDD_DDDD;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s = 2'b00;
    set_std_data();
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0;
    a64 = 64'h0123_4567_89AB_CDEF; b64 = '1; c64 = '0; d64 = 64'h8000_0000_0000_0001;
    exp_yq = '0; exp_yq1 = 1'b0; exp_yq64 = '0; exp_sq = 2'b00;
    #2;
    check_reg("reset_state");
    check_comb("y_during_reset");
    check("y_during_reset_const", y, 64'hAAAA_AAAA);

    // Static select sweep with the register disabled.
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); s = 2'(i);
      #1 check_comb("sweep");
    end
    check("sweep_d_const", y, 64'hDDDD_DDDD);
    check_reg("sweep_no_capture");

    // Registered capture, then a mid-cycle select change.
    @(negedge clk); en = 1'b1; s = 2'b01;
    @(posedge clk); #1;
    check("cap_b_yq", yq, 64'hBBBB_BBBB);
    check("cap_b_sq", sq, 64'h1);
    check_reg("cap_b");
    s = 2'b11;
    #1;
    check("mid_change_y", y, 64'hDDDD_DDDD);
    check("mid_change_yq_hold", yq, 64'hBBBB_BBBB);
    @(posedge clk); #1;
    check("cap_d_yq", yq, 64'hDDDD_DDDD);

    // Enable hold.
    @(negedge clk); s = 2'b10;
    @(posedge clk); #1 check("cap_c_yq", yq, 64'hCCCC_CCCC);
    @(negedge clk); en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s = 2'(k);
      if (k == 1) c = 32'h1234_5678;
      #1 check_comb("hold_live");
      @(posedge clk); #1;
      check("hold_yq", yq, 64'hCCCC_CCCC);
      check("hold_sq", sq, 64'h2);
    end
    s = 2'b10;
    #1 check("hold_new_c", y, 64'h1234_5678);

    // Asynchronous reset between edges.
    @(negedge clk); set_std_data(); en = 1'b1; s = 2'b11;
    @(posedge clk); #1 check("pre_reset_yq", yq, 64'hDDDD_DDDD);
    #2 do_reset("async_reset");
    check("async_reset_yq_const", yq, 64'h0);
    @(posedge clk); #1 check_reg("reset_held_over_edge");
    @(negedge clk); s = 2'b00; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_yq", yq, 64'hAAAA_AAAA);
    check_reg("post_reset");

    // Bit independence.
    @(negedge clk);
    a = 32'h0; b = 32'hFFFF_FFFF; c = 32'h8000_0001; d = 32'h7FFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); s = 2'(i);
      #1 check_comb("bits");
      @(posedge clk); #1 check_reg("bits");
    end
    check("bits_d_yq_const", yq, 64'h7FFF_FFFE);

    // Walking ones on the narrow and wide builds.
    for (int p = 0; p < 64; p++) begin
      @(negedge clk);
      s   = 2'(p % 4);
      a64 = 64'd1 << p;
      b64 = 64'd1 << ((p + 16) % 64);
      c64 = 64'd1 << ((p + 32) % 64);
      d64 = 64'd1 << ((p + 48) % 64);
      a1 = (p % 4 == 0); b1 = (p % 4 == 1); c1 = (p % 4 == 2); d1 = (p % 4 == 3);
      #1 check_comb("walk");
      check("walk_y1_one", y1, 64'h1);
      @(posedge clk); #1 check_reg("walk");
    end

    // Randomised traffic with occasional asynchronous resets.
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      rst_n = 1'b1;
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      c64 = {$urandom, $urandom}; d64 = {$urandom, $urandom};
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); d1 = 1'($urandom);
      s  = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      #1 check_comb("rand");
      if ($urandom_range(0, 15) == 0) do_reset("rand_reset");
      @(posedge clk); #1 check_reg("rand");
      s = 2'($urandom_range(0, 3));
      #1 check_comb("rand_mid");
      check_reg("rand_mid_hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4to1.md
Name: mux4to1

Overview:
- Parameterised N-bit 4-to-1 multiplexer for datapath operand and result selection.
- Provides a combinational output Y that follows the inputs with zero latency.
- Also provides a registered copy Y_Q and a registered select S_Q, for paths that need timing isolation.
- One clock domain; asynchronous active-low reset clears the registered outputs only.

Parameters:
- N, 32, data width in bits of A, B, C, D, Y, Y_Q; legal N >= 1.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- A  input  N  data input, selected when S = 2'b00.
- B  input  N  data input, selected when S = 2'b01.
- C  input  N  data input, selected when S = 2'b10.
- D  input  N  data input, selected when S = 2'b11.
- S  input  2  select.
- EN  input  1  load enable for Y_Q and S_Q.
- Y  output  N  combinational mux output.
- Y_Q  output  N  registered mux output.
- S_Q  output  2  select value captured together with Y_Q.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Y, combinational, zero latency:
  - S=00 -> A; S=01 -> B; S=10 -> C; S=11 -> D.
  - All N bits are passed unmodified; no width extension or truncation.
  - Y is independent of clk, rst_n and EN; it stays valid during reset.
- X/Z on S: Y is don't-care. No case may infer a latch; a default branch drives A.
- Registered path:
  - On a rising clk edge with rst_n=1 and EN=1: Y_Q <= mux(S), S_Q <= S.
  - With EN=0, Y_Q and S_Q hold their values.
  - Latency from input to Y_Q is 1 cycle.
- Reset:
  - rst_n=0 immediately forces Y_Q = 0 and S_Q = 2'b00, with no clock required.
  - Reset asserted mid-operation discards any pending capture.
  - On the first rising edge after rst_n returns to 1, normal capture resumes if EN=1.
- Simultaneous events:
  - An input or select change in the same cycle as a capture edge: the value sampled at the edge is stored.
  - Y reflects the new value immediately.
- Invariant: after any capture, Y_Q equals the value Y had at that clock edge.

Test Plan:
- Static select sweep: A=32'hAAAA_AAAA, B=32'hBBBB_BBBB, C=32'hCCCC_CCCC, D=32'hDDDD_DDDD.
  - Step S through 00,01,10,11, holding each for 10 time units.
  - Required: Y = AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD respectively, each within the same delta.
- Registered capture: EN=1, same data, S=01 before a rising edge.
  - Required: after the edge, Y_Q=32'hBBBB_BBBB and S_Q=01.
  - Change S to 11 mid-cycle: Y=DDDD_DDDD at once; Y_Q stays BBBB_BBBB until the next edge.
- Enable hold: after capturing C (S=10), set EN=0 and sweep S plus change C to 32'h1234_5678 over 3 edges.
  - Required: Y tracks the live inputs; Y_Q stays 32'hCCCC_CCCC and S_Q stays 10.
- Asynchronous reset: with Y_Q=32'hDDDD_DDDD, drop rst_n between clock edges.
  - Required: Y_Q=0 and S_Q=00 immediately; Y still equals the selected input.
  - Release rst_n with EN=1, S=00: Y_Q=32'hAAAA_AAAA after the next edge.
- Bit independence: A=0, B=all-ones, C=32'h8000_0001, D=32'h7FFF_FFFE, sweep S.
  - Required: exact bit patterns on Y, and on Y_Q one cycle later.
- Width: N=1 and N=64 builds with walking-one data on each input.
  - Required: the correct bit position appears on Y/Y_Q for every S.
